fir_out_framer: RTL and testbench
=================================

Name: fir_out_framer

Overview:
- Sits directly downstream of the HLS FIR core in the PL. Consumes its valid-only result port (y / y_ap_vld).
- Buffers results in a small FIFO and re-emits them as AXI4-Stream beats with TLAST every FRAME_LEN samples, for the AXI DMA S2MM channel.
- Results that arrive while the FIFO is full are dropped, and the drop is flagged to software.

Parameters:
- DATA_W, 32, sample width of y and m_axis_tdata.
- FRAME_LEN, 256, beats per frame. TLAST is asserted on the last beat. Legal range 2..65536.
- FIFO_DEPTH, 16, FIFO entries. Power of two, ≥4. The output register is excluded from this count.

Ports:
- ap_clk, in, 1: sole clock.
- ap_rst, in, 1: synchronous, active-high reset.
- y, in, DATA_W: FIR result sample.
- y_ap_vld, in, 1: y valid for one cycle. No ready exists; the core never stalls.
- m_axis_tdata, out, DATA_W: stream data.
- m_axis_tvalid, out, 1: stream valid.
- m_axis_tready, in, 1: stream ready.
- m_axis_tlast, out, 1: last beat of frame.
- fifo_level, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.
- overflow, out, 1: sticky flag, set when a sample is dropped.
- clear_ovf, in, 1: one-cycle pulse that clears overflow.

Behaviour:
- Interface (already decided): one clock, ap_clk; reset ap_rst is synchronous and active-high.
- Reset state:
  - m_axis_tvalid, m_axis_tdata, m_axis_tlast, fifo_level and overflow all 0.
  - FIFO empty; frame counter 0.
  - Reset mid-frame discards all buffered data and the partial frame. The first beat after reset is beat 0 of a new frame.
- FIFO write:
  - Occurs when y_ap_vld=1 and fifo_level<FIFO_DEPTH.
  - Fullness is evaluated on the pre-edge level. If level==FIFO_DEPTH, the sample is dropped even when a pop happens in the same cycle.
- Output register:
  - Loaded from the FIFO head when the FIFO is non-empty and either tvalid=0 or (tvalid & tready).
  - The same cycle's write may not bypass into the output register. Data must pass through the FIFO first.
- Latency: a sample written with y_ap_vld in cycle N, into an empty FIFO with a free output register, gives tvalid=1 in cycle N+2.
- AXI stream rules:
  - While tvalid=1 and tready=0, tdata, tlast and tvalid hold stable.
  - tvalid never drops without a handshake.
- Frame counter:
  - Width clog2(FRAME_LEN). Advances on each handshake (tvalid & tready).
  - tlast = tvalid & (count==FRAME_LEN-1). It is computed for the beat held in the output register.
  - On the tlast handshake the counter wraps to 0.
- fifo_level:
  - +1 on write only; -1 on pop only; unchanged on simultaneous write and pop.
  - Never exceeds FIFO_DEPTH and never underflows.
- Overflow flag:
  - Set on any drop.
  - clear_ovf clears it, but a drop in the same cycle wins and the flag stays 1.
- Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.

Optional Feature:
- Macro: FIR_OUT_FRAMER_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt, 16 bits, reset 0.
  - Increments once per dropped sample and saturates at 16'hFFFF.
  - clear_ovf also zeroes it; a same-cycle drop leaves it at 1.
- When undefined: no drop_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
1. Latency and framing: FRAME_LEN=4, tready=1, y=1..8 on consecutive cycles starting at cycle 0 → tvalid first high at cycle 2; data 1..8 in order; tlast on values 4 and 8 only.
2. Full and drop: FIFO_DEPTH=16, tready=0, y=1..20 on consecutive cycles →
   - output register holds 1; fifo_level=16;
   - samples 18..20 dropped; overflow=1; drop_cnt=3 (if enabled);
   - then tready=1 → exactly 1..17 emitted.
3. Clear race: a drop and clear_ovf in the same cycle → overflow stays 1. A later clear_ovf alone → overflow=0 and drop_cnt=0.
4. Backpressure: FRAME_LEN=4, 12 samples, tready toggling 1/0 each cycle → tdata/tlast never change while tvalid & !tready; tlast on beats 4, 8 and 12.
5. Reset mid-frame: ap_rst for one cycle after 2 handshaken beats → all outputs 0 and fifo_level=0; the next 4 samples emit with tlast on the 4th.
6. Boundary: level=16 with y_ap_vld=1 and a pop in the same cycle → sample dropped; fifo_level=15; overflow=1.

Source files
------------

// File: rtl/fir_out_framer.sv
// Buffers valid-only FIR results in a FIFO and re-emits them as AXI4-Stream frames
// with TLAST every FRAME_LEN beats. Optional drop counter: FIR_OUT_FRAMER_DROP_CNT_EN.
module fir_out_framer #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [DATA_W-1:0]             y,
  input  logic                          y_ap_vld,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     beat_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              drop;
  logic              hs;
  logic              pop;

  // Stream handshake: a beat transfers on any edge where tvalid & tready are both 1;
  // once tvalid is raised, tdata/tlast/tvalid stay frozen until that transfer happens.
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign fifo_empty = (fifo_level == '0);
  assign wr_en      = y_ap_vld && !fifo_full;
  assign drop       = y_ap_vld && fifo_full;
  assign hs         = m_axis_tvalid && m_axis_tready;
  assign pop        = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

  // Fullness uses the pre-edge level, so a pop in the same cycle cannot rescue a sample.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= y;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output register only ever loads from the FIFO head, never from y directly.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (pop) begin
      m_axis_tdata  <= mem[rd_ptr];
      m_axis_tvalid <= 1'b1;
    end else if (hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      beat_cnt <= '0;
    end else if (hs) begin
      beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && (beat_cnt == LAST_CNT);

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      drop_cnt <= '0;
    end else if (clear_ovf) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_framer.sv
// Directed bench for fir_out_framer (FRAME_LEN=4, FIFO_DEPTH=16): latency, framing,
// overflow/drop, clear race, backpressure, mid-frame reset and full-with-pop boundary.
module tb_fir_out_framer;

  localparam int DATA_W     = 32;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 16;

  logic              ap_clk;
  logic              ap_rst;
  logic [DATA_W-1:0] y;
  logic              y_ap_vld;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic              clear_ovf;
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  fir_out_framer #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .y            (y),
    .y_ap_vld     (y_ap_vld),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // Clock / reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                beat_idx = 0;
  int                n_beats  = 0;
  int                n_lasts  = 0;
  bit                hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Checks the current cycle (inputs already driven), then advances one clock.
  task automatic tick();
    logic [DATA_W-1:0] exp_d;
    if (hold_pending) begin
      check("hold_valid", m_axis_tvalid, 1);
      check("hold_data", m_axis_tdata, hold_data);
      check("hold_last", m_axis_tlast, hold_last);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        check("tdata", m_axis_tdata, exp_d);
        check("tlast", m_axis_tlast, beat_idx == FRAME_LEN - 1);
        if (m_axis_tlast) n_lasts++;
        beat_idx = (beat_idx + 1) % FRAME_LEN;
        n_beats++;
      end
    end
    hold_pending = m_axis_tvalid && !m_axis_tready;
    hold_data    = m_axis_tdata;
    hold_last    = m_axis_tlast;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    y_ap_vld  = 1'b0;
    clear_ovf = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    exp_q.delete();
    beat_idx     = 0;
    hold_pending = 1'b0;
  endtask

  task automatic drive_sample(input logic [DATA_W-1:0] v, input bit expect_kept);
    y        = v;
    y_ap_vld = 1'b1;
    if (expect_kept) exp_q.push_back(v);
  endtask

  task automatic drain(input int budget, input bit toggle);
    int t;
    t = 0;
    y_ap_vld = 1'b0;
    while (exp_q.size() != 0 && t < budget) begin
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      tick();
      t++;
    end
    check("drain_done", exp_q.size(), 0);
    check("idle_after_drain", m_axis_tvalid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_overflow"}, overflow, 0);
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    check({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
  endtask

  initial begin
    int guard;
    ap_rst        = 1'b1;
    y             = '0;
    y_ap_vld      = 1'b0;
    m_axis_tready = 1'b0;
    clear_ovf     = 1'b0;
    @(posedge ap_clk);
    #1;
    do_reset();
    check_reset_state("reset");

    // Latency and framing: y=1..8 back to back, tready=1
    m_axis_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) check("latency_n1_tvalid", m_axis_tvalid, 0);
      if (c == 2) begin
        check("latency_n2_tvalid", m_axis_tvalid, 1);
        check("latency_n2_tdata", m_axis_tdata, 1);
      end
      drive_sample(c + 1, 1'b1);
      tick();
    end
    drain(50, 1'b0);
    check("frame_lasts", n_lasts, 2);

    // Full and drop: tready=0, y=1..20; 18..20 dropped
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive_sample(i, i <= 17);
      tick();
    end
    check("full_tvalid", m_axis_tvalid, 1);
    check("full_tdata", m_axis_tdata, 1);
    check("full_level", fifo_level, 16);
    check("full_overflow", overflow, 1);
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    check("full_drop_cnt", drop_cnt, 3);
`endif

    // Boundary: level=16, write and pop in the same cycle -> write dropped
    m_axis_tready = 1'b1;
    drive_sample(32'h99, 1'b0);
    tick();
    y_ap_vld = 1'b0;
    check("boundary_level", fifo_level, 15);
    check("boundary_overflow", overflow, 1);
    check("boundary_tdata", m_axis_tdata, 2);
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    check("boundary_drop_cnt", drop_cnt, 4);
`endif
    drain(50, 1'b0);

    // Clear race: refill, then drop + clear_ovf together, then clear alone
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      drive_sample(32'h100 + i, 1'b1);
      tick();
    end
    check("race_level", fifo_level, 16);
    check("race_pre_overflow", overflow, 0);
    drive_sample(32'h200, 1'b0);
    clear_ovf = 1'b1;
    tick();
    y_ap_vld = 1'b0;
    check("race_overflow", overflow, 1);
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    check("race_drop_cnt", drop_cnt, 1);
`endif
    tick();
    clear_ovf = 1'b0;
    check("clear_overflow", overflow, 0);
`ifdef FIR_OUT_FRAMER_DROP_CNT_EN
    check("clear_drop_cnt", drop_cnt, 0);
`endif
    drain(80, 1'b0);

    // Backpressure: 12 samples, tready toggling every cycle
    do_reset();
    n_lasts = 0;
    for (int i = 0; i < 12; i++) begin
      m_axis_tready = (i % 2 == 0);
      drive_sample(32'h300 + i, 1'b1);
      tick();
    end
    drain(100, 1'b1);
    check("bp_lasts", n_lasts, 3);

    // Reset mid-frame after two handshaken beats
    do_reset();
    m_axis_tready = 1'b1;
    n_beats = 0;
    guard = 0;
    while (n_beats < 2 && guard < 20) begin
      if (guard < 6) drive_sample(32'h400 + guard, 1'b1);
      else y_ap_vld = 1'b0;
      tick();
      guard++;
    end
    check("midframe_beats", n_beats, 2);
    do_reset();
    check_reset_state("midframe_reset");
    n_lasts = 0;
    for (int i = 0; i < 4; i++) begin
      drive_sample(32'h500 + i, 1'b1);
      tick();
    end
    drain(50, 1'b0);
    check("post_reset_lasts", n_lasts, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
